iob_soc_sut_bringup_ctrl: RTL and testbench
===========================================

IOB_SOC_SUT_BRINGUP_CTRL -- requirements
Module: iob_soc_sut_bringup_ctrl

Interface

Parameters
REQ-001 The module SHALL have parameter EXTMEM, default 1: 1 means a DDR3 controller is sequenced; 0 means the DDR states are skipped.
REQ-002 The module SHALL have parameter CNT_W, default 21: the width of the shared cycle counter.
REQ-003 The module SHALL have parameter DDR_RST_CYCLES, default 16: the number of cycles ddr_resetn_o is held low per attempt.
REQ-004 The module SHALL have parameter TIMEOUT_CYCLES, default 1048576: the maximum number of cycles from entry to ST_WAIT_LOCK until init_done is seen.
REQ-005 The module SHALL have parameter PHY_RST_CYCLES, default 1000: the width of the PHY reset pulse in cycles.
REQ-006 The module SHALL have parameter PHY_WAIT_CYCLES, default 2000: the PHY settle time after reset release, in cycles.
REQ-007 The module SHALL have parameter MAX_RETRY, default 3 (legal range 0..3): the number of DDR re-initialisations before ST_FAIL.
REQ-008 Every cycle-count parameter SHALL be in the range 1 to 2^CNT_W-1.

Ports
REQ-009 The module SHALL have port clk_i, input, 1 bit: the single clock.
REQ-010 The module SHALL have port arst_n_i, input, 1 bit: the reset, asynchronous and active-low.
REQ-011 The module SHALL have port pll_locked_i, input, 1 bit: the DDR PLL lock (asynchronous).
REQ-012 The module SHALL have port init_done_i, input, 1 bit: DDR controller init done (asynchronous).
REQ-013 The module SHALL have port cal_fail_i, input, 1 bit: DDR calibration failure (asynchronous).
REQ-014 The module SHALL have port ddr_resetn_o, output, 1 bit: the DDR controller reset, active-low.
REQ-015 The module SHALL have port eth_phy_resetn_o, output, 1 bit: the Ethernet PHY reset, active-low.
REQ-016 The module SHALL have port sys_rst_o, output, 1 bit: the SoC system reset, active-high.
REQ-017 The module SHALL have port ready_o, output, 1 bit: system running.
REQ-018 The module SHALL have port fail_o, output, 1 bit: bring-up failed (sticky).
REQ-019 The module SHALL have port state_o, output, 3 bits: the current state encoding.
REQ-020 The module SHALL have port retry_cnt_o, output, 2 bits: the number of retries since last entry to ST_RUN.

Function
REQ-021 pll_locked_i, init_done_i and cal_fail_i SHALL each pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized values only.
REQ-022 The FSM states and encodings SHALL be: ST_RST=0, ST_DDR_RST=1, ST_WAIT_LOCK=2, ST_WAIT_CAL=3, ST_PHY_RST=4, ST_PHY_WAIT=5, ST_RUN=6, ST_FAIL=7; state_o SHALL equal the state register.
REQ-023 The cycle counter SHALL clear on every state change; a timed state of N cycles SHALL exit when the counter equals N-1.
REQ-024 ST_RST SHALL go to ST_DDR_RST on the first edge after reset release (to ST_PHY_RST if EXTMEM=0).
REQ-025 ST_DDR_RST SHALL go to ST_WAIT_LOCK after DDR_RST_CYCLES.
REQ-026 ST_WAIT_LOCK SHALL go to ST_WAIT_CAL when lock=1; the counter SHALL not clear on this transition (shared timeout).
REQ-027 ST_WAIT_CAL SHALL go to ST_PHY_RST when init_done=1.
REQ-028 If cal_fail=1 in ST_WAIT_CAL, or the counter reaches TIMEOUT_CYCLES-1 in ST_WAIT_LOCK or ST_WAIT_CAL, the FSM SHALL take the retry path.
REQ-029 If cal_fail=1 and init_done=1 are seen in the same cycle, cal_fail SHALL win.
REQ-030 Retry path: if retry_cnt_o < MAX_RETRY, retry_cnt_o SHALL increment and the FSM SHALL go to ST_DDR_RST; otherwise it SHALL go to ST_FAIL.
REQ-031 ST_PHY_RST SHALL go to ST_PHY_WAIT after PHY_RST_CYCLES.
REQ-032 ST_PHY_WAIT SHALL go to ST_RUN after PHY_WAIT_CYCLES.
REQ-033 On entry to ST_RUN, retry_cnt_o SHALL clear to 0.
REQ-034 In ST_RUN with EXTMEM=1, lock=0 or init_done=0 SHALL take the retry path.
REQ-035 ST_FAIL SHALL be terminal and SHALL be exited only by arst_n_i.
REQ-036 Outputs SHALL be registered and SHALL change on the same edge the state register changes, with no combinational glitches.
REQ-037 sys_rst_o SHALL be 1 in every state except ST_RUN; ready_o SHALL be 1 only in ST_RUN; fail_o SHALL be 1 only in ST_FAIL.
REQ-038 ddr_resetn_o SHALL be 0 in ST_RST, ST_DDR_RST and ST_FAIL, and 1 otherwise.
REQ-039 eth_phy_resetn_o SHALL be 1 only in ST_PHY_WAIT and ST_RUN.

Reset
REQ-040 While arst_n_i=0, the module SHALL asynchronously force: state=ST_RST, counter=0, retry_cnt_o=0, synchronizers=0, sys_rst_o=1, ddr_resetn_o=0, eth_phy_resetn_o=0, ready_o=0, fail_o=0.
REQ-041 Reset assertion mid-sequence, including ST_FAIL, SHALL abort immediately, and release SHALL restart from ST_RST.

Verification
Bench parameters: DDR_RST_CYCLES=4, TIMEOUT_CYCLES=64, PHY_RST_CYCLES=8, PHY_WAIT_CYCLES=8, MAX_RETRY=2; k = the first edge sampling init_done_i=1.
REQ-042 Nominal: lock high, then init_done_i high at edge k -> state goes to ST_PHY_RST at k+2, ST_PHY_WAIT at k+10, ST_RUN at k+18 (ready_o=1, sys_rst_o=0); eth_phy_resetn_o is low for exactly 8 cycles.
REQ-043 One cal_fail_i pulse in ST_WAIT_CAL -> retry_cnt_o=1, ddr_resetn_o low for exactly 4 cycles; a later success reaches ST_RUN with retry_cnt_o=0.
REQ-044 pll_locked_i held 0 -> three 64-cycle timeouts -> ST_FAIL with fail_o=1, retry_cnt_o=2, sys_rst_o=1, held indefinitely.
REQ-045 pll_locked_i dropped in ST_RUN -> sys_rst_o=1 and ready_o=0 within 3 cycles, then a full DDR/PHY resequence back to ST_RUN.
REQ-046 arst_n_i pulsed low mid-ST_PHY_WAIT -> all outputs take their reset values with no clock edge; release restarts at ST_RST.
REQ-047 EXTMEM=0 with all DDR inputs tied 0 -> ST_RUN is reached 1+8+8 cycles after reset release.

Source files
------------

// File: rtl/iob_soc_sut_bringup_ctrl.sv
// ---------------------------------------------------------------------------
// iob_soc_sut_bringup_ctrl
//
// Bring-up sequencer for the SoC under test. After reset it sequences the
// DDR3 controller (reset pulse, PLL lock, calibration), then the Ethernet
// PHY (reset pulse, settle time), and finally releases the SoC system reset.
// DDR failures or timeouts are retried a bounded number of times before the
// controller parks in a sticky failure state. With EXTMEM=0 the DDR part of
// the sequence is skipped entirely.
//
// Ports:
//   clk_i            single clock
//   arst_n_i         asynchronous active-low reset
//   pll_locked_i     DDR PLL lock (asynchronous, synchronized here)
//   init_done_i      DDR controller init done (asynchronous, synchronized here)
//   cal_fail_i       DDR calibration failure (asynchronous, synchronized here)
//   ddr_resetn_o     DDR controller reset, active-low
//   eth_phy_resetn_o Ethernet PHY reset, active-low
//   sys_rst_o        SoC system reset, active-high
//   ready_o          system running
//   fail_o           bring-up failed (sticky until arst_n_i)
//   state_o          current state encoding
//   retry_cnt_o      DDR retries since the last entry to ST_RUN
// ---------------------------------------------------------------------------
module iob_soc_sut_bringup_ctrl #(
  parameter int EXTMEM          = 1,
  parameter int CNT_W           = 21,
  parameter int DDR_RST_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES  = 1048576,
  parameter int PHY_RST_CYCLES  = 1000,
  parameter int PHY_WAIT_CYCLES = 2000,
  parameter int MAX_RETRY       = 3
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       pll_locked_i,
  input  logic       init_done_i,
  input  logic       cal_fail_i,
  output logic       ddr_resetn_o,
  output logic       eth_phy_resetn_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_DDR_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_WAIT_CAL  = 3'd3,
    ST_PHY_RST   = 3'd4,
    ST_PHY_WAIT  = 3'd5,
    ST_RUN       = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  // A timed state of N cycles exits on the cycle its counter reads N-1.
  localparam logic [CNT_W-1:0] DDR_RST_LAST  = CNT_W'(DDR_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT   = 2'(MAX_RETRY);
  localparam bit               USE_DDR       = (EXTMEM != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic             take_retry;

  logic [1:0] lock_sync, done_sync, cal_fail_sync;
  logic       lock_s, done_s, cal_fail_s;

  logic ddr_resetn_q, eth_phy_resetn_q, sys_rst_q, ready_q, fail_q;
  logic ddr_resetn_d, eth_phy_resetn_d, sys_rst_d, ready_d, fail_d;

  // Two-flop synchronizers for the asynchronous DDR status inputs. Bit 0 is
  // the metastability-catching stage; only bit 1 is used by the FSM.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      lock_sync     <= 2'b00;
      done_sync     <= 2'b00;
      cal_fail_sync <= 2'b00;
    end else begin
      lock_sync     <= {lock_sync[0], pll_locked_i};
      done_sync     <= {done_sync[0], init_done_i};
      cal_fail_sync <= {cal_fail_sync[0], cal_fail_i};
    end
  end

  assign lock_s     = lock_sync[1];
  assign done_s     = done_sync[1];
  assign cal_fail_s = cal_fail_sync[1];

  // Next-state logic. Every DDR failure (calibration error, timeout, loss of
  // lock/init while running) funnels into a single retry decision at the end
  // so the retry budget is handled in exactly one place.
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    take_retry = 1'b0;

    unique case (state_q)
      ST_RST: begin
        state_d = USE_DDR ? ST_DDR_RST : ST_PHY_RST;
      end
      ST_DDR_RST: begin
        if (cnt_q == DDR_RST_LAST) begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_WAIT_CAL;
        end else if (cnt_q == TIMEOUT_LAST) begin
          take_retry = 1'b1;
        end
      end
      ST_WAIT_CAL: begin
        // Calibration failure outranks a simultaneous init_done.
        if (cal_fail_s) begin
          take_retry = 1'b1;
        end else if (done_s) begin
          state_d = ST_PHY_RST;
        end else if (cnt_q == TIMEOUT_LAST) begin
          take_retry = 1'b1;
        end
      end
      ST_PHY_RST: begin
        if (cnt_q == PHY_RST_LAST) begin
          state_d = ST_PHY_WAIT;
        end
      end
      ST_PHY_WAIT: begin
        if (cnt_q == PHY_WAIT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (USE_DDR && (!lock_s || !done_s)) begin
          take_retry = 1'b1;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase

    if (take_retry) begin
      if (retry_q < RETRY_LIMIT) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_DDR_RST;
      end else begin
        state_d = ST_FAIL;
      end
    end

    // A successful bring-up forgives all previous retries.
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      retry_d = 2'd0;
    end
  end

  // Shared cycle counter. It restarts on every state change except the
  // WAIT_LOCK -> WAIT_CAL step, so the DDR timeout covers both waits
  // together. It saturates rather than wrapping in untimed states.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) &&
        !((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_CAL))) begin
      cnt_d = '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode from the next state, so the registered outputs change on
  // the same edge as the state register and never glitch.
  always_comb begin
    sys_rst_d        = (state_d != ST_RUN);
    ready_d          = (state_d == ST_RUN);
    fail_d           = (state_d == ST_FAIL);
    ddr_resetn_d     = !(state_d inside {ST_RST, ST_DDR_RST, ST_FAIL});
    eth_phy_resetn_d = (state_d inside {ST_PHY_WAIT, ST_RUN});
  end

  // State, counter and retry registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      retry_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Registered outputs; reset values hold every downstream block in reset.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sys_rst_q        <= 1'b1;
      ready_q          <= 1'b0;
      fail_q           <= 1'b0;
      ddr_resetn_q     <= 1'b0;
      eth_phy_resetn_q <= 1'b0;
    end else begin
      sys_rst_q        <= sys_rst_d;
      ready_q          <= ready_d;
      fail_q           <= fail_d;
      ddr_resetn_q     <= ddr_resetn_d;
      eth_phy_resetn_q <= eth_phy_resetn_d;
    end
  end

  assign sys_rst_o        = sys_rst_q;
  assign ready_o          = ready_q;
  assign fail_o           = fail_q;
  assign ddr_resetn_o     = ddr_resetn_q;
  assign eth_phy_resetn_o = eth_phy_resetn_q;
  assign state_o          = state_q;
  assign retry_cnt_o      = retry_q;

endmodule

// File: tb/tb_iob_soc_sut_bringup_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_soc_sut_bringup_ctrl
//
// Randomized episodes (nominal, calibration failure, no lock, loss of lock in
// RUN, reset during PHY_WAIT) drive an EXTMEM=1 instance, compared every
// cycle against a timestamp-based reference model. A second EXTMEM=0
// instance with tied-off DDR inputs shares the reset and is checked against
// its fixed start-up timeline.
// ---------------------------------------------------------------------------
module tb_iob_soc_sut_bringup_ctrl;

  localparam int DDR_RST_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES  = 64;
  localparam int PHY_RST_CYCLES  = 8;
  localparam int PHY_WAIT_CYCLES = 8;
  localparam int MAX_RETRY       = 2;
  localparam int EP_CYCLES       = 260;
  localparam int NUM_EPISODES    = 15;
  localparam int NEVER           = 1000000;

  localparam int M_RST = 0, M_DDR_RST = 1, M_WAIT_LOCK = 2, M_WAIT_CAL = 3;
  localparam int M_PHY_RST = 4, M_PHY_WAIT = 5, M_RUN = 6, M_FAIL = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pll_locked = 1'b0;
  logic init_done = 1'b0;
  logic cal_fail = 1'b0;

  logic       ddr_resetn, eth_phy_resetn, sys_rst, ready, fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  logic       ddr_resetn_x0, eth_phy_resetn_x0, sys_rst_x0, ready_x0, fail_x0;
  logic [2:0] state_x0;
  logic [1:0] retry_cnt_x0;

  int passed = 0;
  int total  = 0;
  int ep_num = 0;

  // Reference model: state, timestamps of state/timeout entry, retries.
  int m_state, m_entry, m_wl_entry, m_retries, n;
  bit lock_h[$];
  bit done_h[$];
  bit cal_h[$];

  // Scenario knobs for the current episode.
  int scen, lock_at, done_at, cf_at, cf_len, drop_at, drop_len;
  bit drop_done;

  always #5 clk = ~clk;

  iob_soc_sut_bringup_ctrl #(
    .EXTMEM(1), .CNT_W(21), .DDR_RST_CYCLES(DDR_RST_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .PHY_RST_CYCLES(PHY_RST_CYCLES),
    .PHY_WAIT_CYCLES(PHY_WAIT_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_i(clk), .arst_n_i(rst_n), .pll_locked_i(pll_locked),
    .init_done_i(init_done), .cal_fail_i(cal_fail),
    .ddr_resetn_o(ddr_resetn), .eth_phy_resetn_o(eth_phy_resetn),
    .sys_rst_o(sys_rst), .ready_o(ready), .fail_o(fail),
    .state_o(state), .retry_cnt_o(retry_cnt)
  );

  iob_soc_sut_bringup_ctrl #(
    .EXTMEM(0), .CNT_W(21), .DDR_RST_CYCLES(DDR_RST_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .PHY_RST_CYCLES(PHY_RST_CYCLES),
    .PHY_WAIT_CYCLES(PHY_WAIT_CYCLES), .MAX_RETRY(MAX_RETRY)
  ) dut_noext (
    .clk_i(clk), .arst_n_i(rst_n), .pll_locked_i(1'b0),
    .init_done_i(1'b0), .cal_fail_i(1'b0),
    .ddr_resetn_o(ddr_resetn_x0), .eth_phy_resetn_o(eth_phy_resetn_x0),
    .sys_rst_o(sys_rst_x0), .ready_o(ready_x0), .fail_o(fail_x0),
    .state_o(state_x0), .retry_cnt_o(retry_cnt_x0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: actual %0d required %0d (episode %0d cycle %0d)",
               tag, actual, expected, ep_num, n);
    end
  endtask

  task automatic model_reset();
    m_state    = M_RST;
    m_entry    = 0;
    m_wl_entry = 0;
    m_retries  = 0;
    n          = 0;
    lock_h.delete();
    done_h.delete();
    cal_h.delete();
  endtask

  task automatic enter(input int s);
    m_state = s;
    m_entry = n;
  endtask

  // One clock edge of the model. A timed state of N cycles entered at edge e
  // leaves at edge e+N; inputs reach the decision two edges after sampling.
  task automatic model_step();
    bit l, d, f, retry;
    n++;
    l = (n >= 3) ? lock_h[n-3] : 1'b0;
    d = (n >= 3) ? done_h[n-3] : 1'b0;
    f = (n >= 3) ? cal_h[n-3]  : 1'b0;
    lock_h.push_back(pll_locked);
    done_h.push_back(init_done);
    cal_h.push_back(cal_fail);
    retry = 1'b0;
    case (m_state)
      M_RST:       enter(M_DDR_RST);
      M_DDR_RST:   if (n - m_entry == DDR_RST_CYCLES) begin
                     enter(M_WAIT_LOCK);
                     m_wl_entry = n;
                   end
      M_WAIT_LOCK: if (l) m_state = M_WAIT_CAL;
                   else if (n - m_wl_entry == TIMEOUT_CYCLES) retry = 1'b1;
      M_WAIT_CAL:  if (f) retry = 1'b1;
                   else if (d) enter(M_PHY_RST);
                   else if (n - m_wl_entry == TIMEOUT_CYCLES) retry = 1'b1;
      M_PHY_RST:   if (n - m_entry == PHY_RST_CYCLES) enter(M_PHY_WAIT);
      M_PHY_WAIT:  if (n - m_entry == PHY_WAIT_CYCLES) begin
                     enter(M_RUN);
                     m_retries = 0;
                   end
      M_RUN:       if (!l || !d) retry = 1'b1;
      default:     ;
    endcase
    if (retry) begin
      if (m_retries < MAX_RETRY) begin
        m_retries++;
        enter(M_DDR_RST);
      end else begin
        enter(M_FAIL);
      end
    end
  endtask

  function automatic int noext_expected(input int cyc);
    if (cyc < 1) return M_RST;
    if (cyc < 1 + PHY_RST_CYCLES) return M_PHY_RST;
    if (cyc < 1 + PHY_RST_CYCLES + PHY_WAIT_CYCLES) return M_PHY_WAIT;
    return M_RUN;
  endfunction

  task automatic check_all();
    int e2;
    checkOutput("state_o", 32'(state), m_state);
    checkOutput("retry_cnt_o", 32'(retry_cnt), m_retries);
    checkOutput("sys_rst_o", 32'(sys_rst), 32'(m_state != M_RUN));
    checkOutput("ready_o", 32'(ready), 32'(m_state == M_RUN));
    checkOutput("fail_o", 32'(fail), 32'(m_state == M_FAIL));
    checkOutput("ddr_resetn_o", 32'(ddr_resetn),
                32'(!(m_state == M_RST || m_state == M_DDR_RST || m_state == M_FAIL)));
    checkOutput("eth_phy_resetn_o", 32'(eth_phy_resetn),
                32'(m_state == M_PHY_WAIT || m_state == M_RUN));
    e2 = noext_expected(n);
    checkOutput("noext_state_o", 32'(state_x0), e2);
    checkOutput("noext_ready_o", 32'(ready_x0), 32'(e2 == M_RUN));
    checkOutput("noext_ddr_resetn_o", 32'(ddr_resetn_x0), 32'(e2 != M_RST));
  endtask

  task automatic applyStimulus(input int c);
    bit in_drop;
    in_drop    = (c >= drop_at) && (c < drop_at + drop_len);
    pll_locked = (c >= lock_at) && !(in_drop && !drop_done);
    init_done  = (c >= done_at) && !(in_drop && drop_done);
    cal_fail   = (c >= cf_at) && (c < cf_at + cf_len);
  endtask

  task automatic pick_scenario(input int s);
    lock_at   = $urandom_range(1, 20);
    done_at   = lock_at + $urandom_range(1, 30);
    cf_at     = NEVER;
    cf_len    = 0;
    drop_at   = NEVER;
    drop_len  = 0;
    drop_done = 1'b0;
    case (s)
      1: begin
        cf_at  = lock_at + $urandom_range(3, 12);
        cf_len = $urandom_range(1, 3);
        done_at = ($urandom_range(0, 1) == 1) ? cf_at : cf_at + $urandom_range(5, 25);
      end
      2: lock_at = NEVER;
      3: begin
        drop_at   = done_at + $urandom_range(25, 40);
        drop_len  = $urandom_range(1, 4);
        drop_done = ($urandom_range(0, 1) == 1);
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    for (int ep = 0; ep < NUM_EPISODES; ep++) begin
      ep_num = ep;
      scen   = ep % 5;
      pick_scenario(scen);

      // Assert reset between edges and look at the outputs before any edge.
      @(posedge clk);
      #3;
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      init_done  = 1'b0;
      cal_fail   = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      for (int c = 1; c <= EP_CYCLES; c++) begin
        applyStimulus(c);
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (scen == 4 && m_state == M_PHY_WAIT && (n - m_entry) == 3) break;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
